// File: rtl/sdrc_width_pkg.sv
// Shared SDRAM width encodings and helpers for the application/SDRAM width adapter.
// Width and ratio are computed at run time from the sdr_width mode input.
package sdrc_width_pkg;

  typedef enum logic [1:0] {
    W32 = 2'b00,
    W16 = 2'b01,
    W8  = 2'b10
  } sdr_width_e;

  // Mode 2'b11 aliases the quarter-width mode.
  function automatic int unsigned width_bits(logic [1:0] mode, int unsigned sdr_dw);
    if (mode[1]) begin
      return sdr_dw / 4;
    end else if (mode == W16) begin
      return sdr_dw / 2;
    end
    return sdr_dw;
  endfunction

  function automatic int unsigned ratio(logic [1:0] mode, int unsigned app_dw,
                                        int unsigned sdr_dw);
    return app_dw / width_bits(mode, sdr_dw);
  endfunction

endpackage

// File: rtl/sdrc_lane_sel.sv
// Selects beat idx of the application word at the current SDRAM width.
// Data lanes above W are forced to 0 and enable lanes above W/8 to 1 (disabled).
module sdrc_lane_sel
  import sdrc_width_pkg::*;
#(
  parameter int unsigned APP_DW = 64,
  parameter int unsigned SDR_DW = 32,
  parameter int unsigned CW     = 3
) (
  input  logic [1:0]          sdr_width,
  input  logic [CW-1:0]       idx,
  input  logic [APP_DW-1:0]   data,
  input  logic [APP_DW/8-1:0] en_n,
  output logic [SDR_DW-1:0]   lane_data,
  output logic [SDR_DW/8-1:0] lane_en_n
);

  localparam int unsigned APP_BW = APP_DW / 8;
  localparam int unsigned SDR_BW = SDR_DW / 8;
  localparam int unsigned XW     = (APP_DW > SDR_DW) ? APP_DW : SDR_DW;
  localparam int unsigned XB     = XW / 8;

  int unsigned     w;
  logic [XW-1:0]   data_sh;
  logic [XB-1:0]   en_sh;
  logic [SDR_DW-1:0] dmask;
  logic [SDR_BW-1:0] bmask;

  always_comb begin
    w         = width_bits(sdr_width, SDR_DW);
    data_sh   = XW'(data) >> (32'(idx) * w);
    en_sh     = XB'(en_n) >> (32'(idx) * (w / 8));
    dmask     = {SDR_DW{1'b1}} >> (SDR_DW - w);
    bmask     = {SDR_BW{1'b1}} >> (SDR_BW - w / 8);
    lane_data = data_sh[SDR_DW-1:0] & dmask;
    lane_en_n = en_sh[SDR_BW-1:0] | ~bmask;
  end

  logic unused_bw;
  assign unused_bw = ^APP_BW;

endmodule

// File: rtl/sdrc_width_adapter.sv
// Adapts wide application words to narrow SDRAM beats (write) and assembles
// SDRAM beats back into application words (read); width selectable at run time.
module sdrc_width_adapter
  import sdrc_width_pkg::*;
#(
  parameter int unsigned  APP_DW = 64,
  parameter int unsigned  SDR_DW = 32,
  localparam int unsigned APP_BW = APP_DW / 8,
  localparam int unsigned SDR_BW = SDR_DW / 8,
  localparam int unsigned CW     = $clog2(APP_DW / (SDR_DW / 4))
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        sdr_width,
  input  logic              x2a_wrstart,
  input  logic              x2a_wrnext,
  input  logic              x2a_wrlast,
  output logic [SDR_DW-1:0] a2x_wrdt,
  output logic [SDR_BW-1:0] a2x_wren_n,
  input  logic [APP_DW-1:0] app_wr_data,
  input  logic [APP_BW-1:0] app_wr_en_n,
  output logic              app_wr_next,
  output logic              app_last_wr,
  input  logic              x2a_rdstart,
  input  logic              x2a_rdok,
  input  logic              x2a_rdlast,
  input  logic [SDR_DW-1:0] x2a_rddt,
  output logic [APP_DW-1:0] app_rd_data,
  output logic              app_rd_valid,
  output logic              app_last_rd,
  output logic              app_rd_partial,
  output logic              mode_err
);

  localparam int unsigned XW = (APP_DW > SDR_DW) ? APP_DW : SDR_DW;

  int unsigned   w;
  logic [CW-1:0] r_max;

  assign w     = width_bits(sdr_width, SDR_DW);
  assign r_max = CW'(ratio(sdr_width, APP_DW, SDR_DW) - 1);

  // Write path
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (x2a_wrstart || x2a_wrlast) begin
      wr_cnt_d = '0;
    end else if (x2a_wrnext) begin
      wr_cnt_d = (wr_cnt_q == r_max) ? '0 : wr_cnt_q + 1'b1;
    end
  end

  sdrc_lane_sel #(
    .APP_DW(APP_DW),
    .SDR_DW(SDR_DW),
    .CW    (CW)
  ) u_lane_sel (
    .sdr_width(sdr_width),
    .idx      (wr_cnt_q),
    .data     (app_wr_data),
    .en_n     (app_wr_en_n),
    .lane_data(a2x_wrdt),
    .lane_en_n(a2x_wren_n)
  );

  assign app_wr_next = x2a_wrnext & ((wr_cnt_q == r_max) | x2a_wrlast);
  assign app_last_wr = x2a_wrlast & x2a_wrnext;

  // Read path
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d, rd_lane;
  logic [APP_DW-1:0] asm_q, asm_d, rd_base, asm_merged;
  logic [APP_DW-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_part_q, rd_part_d;
  logic              rd_emit;
  logic [XW-1:0]     lane_mask_x, beat_x;
  logic [1:0]        width_q;
  logic              mode_err_q, mode_err_d;

  always_comb begin
    // A start coinciding with a beat restarts assembly at lane 0.
    rd_lane     = x2a_rdstart ? '0 : rd_cnt_q;
    rd_base     = x2a_rdstart ? '0 : asm_q;
    lane_mask_x = XW'({SDR_DW{1'b1}} >> (SDR_DW - w)) << (32'(rd_lane) * w);
    beat_x      = XW'(x2a_rddt & ({SDR_DW{1'b1}} >> (SDR_DW - w))) << (32'(rd_lane) * w);
    asm_merged  = (rd_base & ~lane_mask_x[APP_DW-1:0]) | beat_x[APP_DW-1:0];
    rd_emit     = x2a_rdok && ((rd_lane == r_max) || x2a_rdlast);

    rd_cnt_d   = rd_cnt_q;
    asm_d      = asm_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_part_d  = 1'b0;
    if (rd_emit) begin
      rd_data_d  = asm_merged;
      rd_valid_d = 1'b1;
      rd_last_d  = x2a_rdlast;
      rd_part_d  = x2a_rdlast && (rd_lane != r_max);
      asm_d      = '0;
      rd_cnt_d   = '0;
    end else if (x2a_rdok) begin
      asm_d    = asm_merged;
      rd_cnt_d = rd_lane + 1'b1;
    end else if (x2a_rdstart) begin
      asm_d    = '0;
      rd_cnt_d = '0;
    end

    mode_err_d = mode_err_q |
                 ((sdr_width != width_q) && ((wr_cnt_q != '0) || (rd_cnt_q != '0)));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      asm_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_part_q  <= 1'b0;
      mode_err_q <= 1'b0;
      width_q    <= sdr_width;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      asm_q      <= asm_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_part_q  <= rd_part_d;
      mode_err_q <= mode_err_d;
      width_q    <= sdr_width;
    end
  end

  assign app_rd_data    = rd_data_q;
  assign app_rd_valid   = rd_valid_q;
  assign app_last_rd    = rd_last_q;
  assign app_rd_partial = rd_part_q;
  assign mode_err       = mode_err_q;

endmodule

// File: tb/tb_sdrc_width_adapter.sv
// Bench for sdrc_width_adapter: beat-list reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sdrc_width_adapter;

  localparam int unsigned APP_DW = 64;
  localparam int unsigned SDR_DW = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  sdr_width;
  logic        x2a_wrstart, x2a_wrnext, x2a_wrlast;
  logic [31:0] a2x_wrdt;
  logic [3:0]  a2x_wren_n;
  logic [63:0] app_wr_data;
  logic [7:0]  app_wr_en_n;
  logic        app_wr_next, app_last_wr;
  logic        x2a_rdstart, x2a_rdok, x2a_rdlast;
  logic [31:0] x2a_rddt;
  logic [63:0] app_rd_data;
  logic        app_rd_valid, app_last_rd, app_rd_partial, mode_err;

  always #5 clk = ~clk;

  sdrc_width_adapter #(
    .APP_DW(APP_DW),
    .SDR_DW(SDR_DW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sdr_width     (sdr_width),
    .x2a_wrstart   (x2a_wrstart),
    .x2a_wrnext    (x2a_wrnext),
    .x2a_wrlast    (x2a_wrlast),
    .a2x_wrdt      (a2x_wrdt),
    .a2x_wren_n    (a2x_wren_n),
    .app_wr_data   (app_wr_data),
    .app_wr_en_n   (app_wr_en_n),
    .app_wr_next   (app_wr_next),
    .app_last_wr   (app_last_wr),
    .x2a_rdstart   (x2a_rdstart),
    .x2a_rdok      (x2a_rdok),
    .x2a_rdlast    (x2a_rdlast),
    .x2a_rddt      (x2a_rddt),
    .app_rd_data   (app_rd_data),
    .app_rd_valid  (app_rd_valid),
    .app_last_rd   (app_last_rd),
    .app_rd_partial(app_rd_partial),
    .mode_err      (mode_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned wbits(input logic [1:0] m);
    return (m == 2'b00) ? 32 : ((m == 2'b01) ? 16 : 8);
  endfunction

  // Reference model: write beat index and the list of read beats received so far.
  int unsigned m_wbeat;
  logic [31:0] m_beats[$];
  logic [63:0] e_data;
  bit          e_valid, e_last, e_part, e_err;
  logic [1:0]  m_prev;

  initial begin
    forever begin
      @(posedge clk);
      begin
        int unsigned w, r;
        logic [63:0] msk, word;
        w   = wbits(sdr_width);
        r   = 64 / w;
        msk = (64'd1 << w) - 64'd1;
        if (!reset_n) begin
          m_wbeat = 0;
          m_beats.delete();
          e_data  = '0;
          e_valid = 1'b0;
          e_last  = 1'b0;
          e_part  = 1'b0;
          e_err   = 1'b0;
          m_prev  = sdr_width;
        end else begin
          if (sdr_width != m_prev && (m_wbeat != 0 || m_beats.size() != 0)) e_err = 1'b1;
          m_prev = sdr_width;
          if (x2a_wrstart || x2a_wrlast) m_wbeat = 0;
          else if (x2a_wrnext) m_wbeat = (m_wbeat + 1) % r;
          e_valid = 1'b0;
          e_last  = 1'b0;
          e_part  = 1'b0;
          if (x2a_rdstart) m_beats.delete();
          if (x2a_rdok) begin
            m_beats.push_back(x2a_rddt & msk[31:0]);
            if (m_beats.size() == r || x2a_rdlast) begin
              word = '0;
              foreach (m_beats[i]) word = word | (64'(m_beats[i]) << (i * w));
              e_data  = word;
              e_valid = 1'b1;
              e_last  = x2a_rdlast;
              e_part  = x2a_rdlast && (m_beats.size() != r);
              m_beats.delete();
            end
          end
        end
        started = 1'b1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        int unsigned w;
        logic [63:0] t, msk;
        logic [3:0]  ew;
        w   = wbits(sdr_width);
        msk = (64'd1 << w) - 64'd1;
        t   = app_wr_data >> (m_wbeat * w);
        for (int j = 0; j < 4; j++)
          ew[j] = (j < int'(w / 8)) ? app_wr_en_n[m_wbeat * (w / 8) + j] : 1'b1;
        chk("model wrdt", a2x_wrdt, t[31:0] & msk[31:0]);
        chk("model wren_n", a2x_wren_n, ew);
        chk("model wr_next", app_wr_next,
            x2a_wrnext && ((m_wbeat == 64 / w - 1) || x2a_wrlast));
        chk("model last_wr", app_last_wr, x2a_wrlast && x2a_wrnext);
        chk("model rd_valid", app_rd_valid, e_valid);
        chk("model rd_data", app_rd_data, e_data);
        chk("model last_rd", app_last_rd, e_last);
        chk("model rd_partial", app_rd_partial, e_part);
        chk("model mode_err", mode_err, e_err);
      end
    end
  end

  task automatic drive(input logic rs, input logic ok, input logic rl, input logic [31:0] d,
                       input logic ws, input logic wn, input logic wl);
    @(posedge clk);
    #1;
    x2a_rdstart = rs;
    x2a_rdok    = ok;
    x2a_rdlast  = rl;
    x2a_rddt    = d;
    x2a_wrstart = ws;
    x2a_wrnext  = wn;
    x2a_wrlast  = wl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] exp30[4];

  initial begin
    reset_n     = 1'b0;
    sdr_width   = 2'b00;
    x2a_wrstart = 1'b0;
    x2a_wrnext  = 1'b0;
    x2a_wrlast  = 1'b0;
    x2a_rdstart = 1'b0;
    x2a_rdok    = 1'b0;
    x2a_rdlast  = 1'b0;
    x2a_rddt    = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    exp30[0] = 16'h4444;
    exp30[1] = 16'h3333;
    exp30[2] = 16'h2222;
    exp30[3] = 16'h1111;

    @(posedge clk);
    @(negedge clk);
    chk("reset rd_valid", app_rd_valid, 1'b0);
    chk("reset rd_data", app_rd_data, 64'h0);
    chk("reset mode_err", mode_err, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Half-width write burst of four beats.
    sdr_width   = 2'b01;
    app_wr_data = 64'h1111_2222_3333_4444;
    app_wr_en_n = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("wr16 data", a2x_wrdt, {16'h0, exp30[i]});
      chk("wr16 wren_n", a2x_wren_n, 4'b1100);
      chk("wr16 wr_next", app_wr_next, i == 3);
    end

    // Quarter-width partial write burst ending on the third beat.
    idle();
    sdr_width   = 2'b10;
    app_wr_data = 64'h8877_6655_4433_2211;
    app_wr_en_n = 8'h5A;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("wr8 last data", a2x_wrdt, 32'h0000_0033);
    chk("wr8 last wren_n", a2x_wren_n, 4'b1110);
    chk("wr8 last wr_next", app_wr_next, 1'b1);
    chk("wr8 last_wr", app_last_wr, 1'b1);

    // Quarter-width read of eight beats.
    idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 1'b0, 32'(i), 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("rd8 valid", app_rd_valid, 1'b1);
    chk("rd8 data", app_rd_data, 64'h0807_0605_0403_0201);
    chk("rd8 partial", app_rd_partial, 1'b0);
    idle();
    @(negedge clk);
    chk("rd8 valid drop", app_rd_valid, 1'b0);
    chk("rd8 data hold", app_rd_data, 64'h0807_0605_0403_0201);

    // Full-width single-beat partial read.
    sdr_width = 2'b00;
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("rd32 valid", app_rd_valid, 1'b1);
    chk("rd32 data", app_rd_data, 64'h0000_0000_DEAD_BEEF);
    chk("rd32 last", app_last_rd, 1'b1);
    chk("rd32 partial", app_rd_partial, 1'b1);

    // Restart with a beat on top of three stale beats.
    idle();
    sdr_width = 2'b01;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_AAAA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_BBBB, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_CCCC, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_BEEF, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3333, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("restart valid", app_rd_valid, 1'b1);
    chk("restart data", app_rd_data, 64'h3333_2222_1111_BEEF);

    // Reset in the middle of a read burst.
    idle();
    sdr_width = 2'b10;
    drive(1'b1, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    idle();
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst valid", app_rd_valid, 1'b0);
    chk("midrst data", app_rd_data, 64'h0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("midrst word valid", app_rd_valid, 1'b1);
    chk("midrst word data", app_rd_data, 64'hA7A6_A5A4_A3A2_A1A0);

    // Width change mid-burst raises a sticky error.
    idle();
    sdr_width = 2'b01;
    drive(1'b1, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h5678, 1'b0, 1'b0, 1'b0);
    idle();
    sdr_width = 2'b00;
    idle();
    @(negedge clk);
    chk("mode_err set", mode_err, 1'b1);
    repeat (3) idle();
    @(negedge clk);
    chk("mode_err sticky", mode_err, 1'b1);
    idle();
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mode_err cleared", mode_err, 1'b0);

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
